gbn_tx_scheduler: RTL
=====================

Name: gbn_tx_scheduler

Overview:
Go-back-N transmit scheduler for the TCP data phase. Once mainfsm reaches the data state, this block decides which sequence number the packet builder sends next. It tracks the unacknowledged window [base, next_seq) and advances base on cumulative ACKs. On timeout it rewinds next_seq to base and retransmits.

Parameters:
TIMEOUT, 32'd65_000_000, retransmit timeout in clk cycles (1 s at 65 MHz)
TW, 32, timer counter width

Ports:
clk  in  1  system clock (65 MHz)
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begin transfer from ISN
abort  in  1  one-cycle pulse; return to IDLE (e.g. RST/FIN from mainfsm)
ISN  in  32  first data sequence number
SNmax  in  32  last sequence number to send (inclusive)
window  in  16  go-back-N window in packets; 0 treated as 1
ack_valid  in  1  one-cycle strobe; ack_num valid
ack_num  in  32  cumulative ACK = next sequence expected by peer
tx_ready  in  1  packet builder can accept a request
tx_valid  out  1  request to send packet tx_seq
tx_seq  out  32  sequence number to send (equals next_seq)
base  out  32  oldest unacknowledged sequence number
busy  out  1  high in SEND
done  out  1  high in DONE (all of ISN..SNmax acknowledged)
retx_count  out  8  number of timeouts since start, saturating at 255

Behaviour:
- Reset values: state=IDLE, base=0, next_seq=0, timer=0, retx_count=0; tx_valid=0, busy=0, done=0, tx_seq=0.
- Arithmetic: all sequence numbers are unsigned 32-bit. No wrap within a transfer; the caller guarantees SNmax < 2^32-1. The window limit is base + {16'd0, win_eff}, computed at 33 bits.
- States: IDLE, SEND, DONE.
- IDLE to SEND on start: base<=ISN, next_seq<=ISN, timer<=0, retx_count<=0.
  - If SNmax < ISN, go straight to DONE instead.
- tx_valid (combinational) = state==SEND && next_seq <= SNmax && next_seq < base+win_eff.
- Transfer: occurs in a cycle with tx_valid && tx_ready. next_seq <= next_seq+1 on the following edge. tx_seq follows next_seq, so latency from accept to the new tx_seq is 1 cycle.
- ACK handling (SEND only): accept when ack_valid && ack_num > base && ack_num <= next_seq.
  - On accept: base<=ack_num, timer<=0.
  - Otherwise (duplicate, stale or beyond next_seq) ignore the ACK; no state change.
- Timer:
  - Counts while SEND and base != next_seq.
  - Held at 0 when base == next_seq.
  - Expires when timer == TIMEOUT-1. On expiry: next_seq<=base, timer<=0, retx_count+=1 (saturating).
- Simultaneous events, same cycle:
  - ACK accept + transfer: both apply (base from ACK, next_seq+1).
  - ACK accept + expiry: ACK wins; no rewind and retx_count unchanged.
  - Expiry + transfer: the transfer counts as sent, but next_seq<=base (rewind overrides the increment).
- SEND to DONE: when base > SNmax after an update (i.e. ack_num == SNmax+1 accepted). DONE is held until start (restarts the transfer) or abort/reset.
- abort in any state goes to IDLE next cycle and clears tx_valid. Outputs base, tx_seq and retx_count hold their last values.
- start while in SEND restarts from ISN (re-latches; same as the IDLE path).
- reset overrides all inputs.
- ISN, SNmax and window are sampled combinationally each cycle. The caller holds them stable during SEND.

Test Plan:
1. Reset, then start with ISN=0, SNmax=10, window=3, tx_ready=1, no ACKs. Required: tx_seq 0,1,2 accepted on 3 consecutive cycles, then tx_valid=0 with base=0, next_seq=3.
2. From (1), ack_num=2. Required: base=2, timer cleared, then seq 3,4 sent and tx_valid drops at next_seq=5. Then ack_num=1 (stale) and ack_num=9 (beyond next_seq). Required: both ignored, base stays 2.
3. TIMEOUT=16, window=3, SNmax=10, no ACKs after 0,1,2 sent. Required: 16 cycles after the first send, next_seq=0 and retx_count=1; seq 0,1,2 re-sent.
4. Full run with ACKs 3,6,9,11. Required: done=1 one cycle after ack_num=11 with base=11 and busy=0; a further ack_valid causes no change.
5. Same-cycle ack_num=next_seq with timer expiry. Required: no rewind, retx_count unchanged. Same-cycle transfer with expiry: next_seq=base.
6. Edge cases:
   - abort mid-SEND: IDLE next cycle, tx_valid=0.
   - start with ISN=5, SNmax=4: DONE immediately.
   - window=0: behaves as 1 (one outstanding packet).
   - reset asserted mid-transfer: all outputs take their reset values next cycle.

Source files
------------

// File: rtl/gbn_tx_scheduler.sv
// Go-back-N transmit scheduler: tracks the unacknowledged window [base, next_seq),
// issues sequence numbers to the packet builder and rewinds to base on timeout.
module gbn_tx_scheduler #(
    parameter logic [31:0] TIMEOUT = 32'd65_000_000,
    parameter int          TW      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] ISN,
    input  logic [31:0] SNmax,
    input  logic [15:0] window,
    input  logic        ack_valid,
    input  logic [31:0] ack_num,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [31:0] tx_seq,
    output logic [31:0] base,
    output logic        busy,
    output logic        done,
    output logic [7:0]  retx_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 32'd1);

    state_t        state_r, state_s;
    logic [31:0]   base_r, base_s;
    logic [31:0]   next_seq_r, next_seq_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [7:0]    retx_r, retx_s;

    logic [15:0]   win_eff_s;
    logic [32:0]   limit_s;
    logic          tx_valid_s;
    logic          xfer_s;
    logic          ack_ok_s;
    logic          expire_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Window limit, send qualification, ACK acceptance and timer expiry.
    always_comb begin
        win_eff_s  = (window == 16'd0) ? 16'd1 : window;
        // 33-bit so a window reaching past 2^32-1 cannot alias to a small limit
        limit_s    = {1'b0, base_r} + {17'd0, win_eff_s};
        tx_valid_s = (state_r == SEND) && (next_seq_r <= SNmax)
                     && ({1'b0, next_seq_r} < limit_s);
        xfer_s     = tx_valid_s && tx_ready;
        ack_ok_s   = (state_r == SEND) && ack_valid
                     && (ack_num > base_r) && (ack_num <= next_seq_r);
        expire_s   = (state_r == SEND) && (base_r != next_seq_r)
                     && (timer_r == TIMER_LAST);
    end

    // Next-state and datapath update; abort beats start, start beats SEND activity.
    always_comb begin
        state_s    = state_r;
        base_s     = base_r;
        next_seq_s = next_seq_r;
        timer_s    = timer_r;
        retx_s     = retx_r;
        if (abort) begin
            state_s = IDLE;
        end else if (start) begin
            base_s     = ISN;
            next_seq_s = ISN;
            timer_s    = '0;
            retx_s     = 8'd0;
            state_s    = (SNmax < ISN) ? DONE : SEND;
        end else begin
            case (state_r)
                SEND: begin
                    if (ack_ok_s) begin
                        base_s  = ack_num;
                        timer_s = '0;
                    end else if (expire_s) begin
                        timer_s = '0;
                        retx_s  = sat_inc8(retx_r);
                    end else if (base_r == next_seq_r) begin
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + TW'(1);
                    end
                    // An accepted ACK suppresses the rewind; a rewind overrides a transfer.
                    if (expire_s && !ack_ok_s) begin
                        next_seq_s = base_r;
                    end else if (xfer_s) begin
                        next_seq_s = next_seq_r + 32'd1;
                    end else begin
                        next_seq_s = next_seq_r;
                    end
                    if (base_s > SNmax) begin
                        state_s = DONE;
                    end else begin
                        state_s = SEND;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            base_r     <= 32'd0;
            next_seq_r <= 32'd0;
            timer_r    <= '0;
            retx_r     <= 8'd0;
        end else begin
            state_r    <= state_s;
            base_r     <= base_s;
            next_seq_r <= next_seq_s;
            timer_r    <= timer_s;
            retx_r     <= retx_s;
        end
    end

    assign tx_valid   = tx_valid_s;
    assign tx_seq     = next_seq_r;
    assign base       = base_r;
    assign busy       = (state_r == SEND);
    assign done       = (state_r == DONE);
    assign retx_count = retx_r;

endmodule
